// File: rtl/alu_req_gen.sv
// Burst request generator for the 64-bit valid/ready ALU: issues a programmed
// run of operations and folds every accepted result into a rotate-XOR signature.
module alu_req_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [63:0]      cfg_in1,
  input  logic [63:0]      cfg_in2,
  input  logic [63:0]      cfg_step,
  input  logic [2:0]       cfg_op,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             rsp_hold,
  output logic             busy,
  output logic             done,
  output logic [63:0]      signature,
  output logic [63:0]      last_res,
  output logic [CNT_W-1:0] rsp_count,
  output logic [63:0]      alu_in1,
  output logic [63:0]      alu_in2,
  output logic [2:0]       alu_op,
  output logic             alu_in_valid,
  input  logic             alu_in_ready,
  input  logic [63:0]      alu_res,
  input  logic             alu_out_valid,
  output logic             alu_out_ready
);

  localparam int DATA_W = 64;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic [DATA_W-1:0] step_val;

  logic start_go;
  logic req_hs;
  logic rsp_hs;
  logic issue_last;
  logic rsp_last;

  // Rotate left by one, then fold in the new result.
  function automatic logic [DATA_W-1:0] sig_fold(input logic [DATA_W-1:0] sig,
                                                 input logic [DATA_W-1:0] res);
    sig_fold = {sig[DATA_W-2:0], sig[DATA_W-1]} ^ res;
  endfunction

  assign start_go   = (state == IDLE) && start;
  assign req_hs     = alu_in_valid && alu_in_ready;
  assign rsp_hs     = alu_out_valid && alu_out_ready;
  assign issue_last = req_hs && ((issue_cnt + CNT_ONE) == burst_cnt);
  // Count is complete either already or through a response on this edge.
  assign rsp_last   = (rsp_count == burst_cnt) ||
                      (rsp_hs && ((rsp_count + CNT_ONE) == burst_cnt));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (cfg_count == '0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (issue_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (rsp_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    alu_in_valid  = 1'b0;
    alu_out_ready = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    unique case (state)
      ISSUE: begin
        alu_in_valid  = 1'b1;
        alu_out_ready = ~rsp_hold;
        busy          = 1'b1;
      end
      DRAIN: begin
        alu_out_ready = ~rsp_hold;
        busy          = 1'b1;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        alu_in_valid  = 1'b0;
      end
    endcase
  end

  // Request side: operands are loaded on start and in1 steps on each accept.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      alu_in1   <= '0;
      alu_in2   <= '0;
      alu_op    <= '0;
      step_val  <= '0;
      burst_cnt <= '0;
      issue_cnt <= '0;
    end else if (start_go) begin
      if (cfg_count != '0) begin
        alu_in1   <= cfg_in1;
        alu_in2   <= cfg_in2;
        alu_op    <= cfg_op;
        step_val  <= cfg_step;
        burst_cnt <= cfg_count;
        issue_cnt <= '0;
      end
    end else if (req_hs) begin
      issue_cnt <= issue_cnt + CNT_ONE;
      alu_in1   <= alu_in1 + step_val;
    end
  end

  // Response side: results persist after completion until the next start.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      signature <= '0;
      last_res  <= '0;
      rsp_count <= '0;
    end else if (start_go) begin
      signature <= '0;
      rsp_count <= '0;
    end else if (rsp_hs) begin
      signature <= sig_fold(signature, alu_res);
      last_res  <= alu_res;
      rsp_count <= rsp_count + CNT_ONE;
    end
  end

endmodule

// File: doc/alu_req_gen.md
Name: alu_req_gen

Overview:
- Initiator for the 64-bit ALU valid/ready interface. It drives operand/op requests into the ALU and consumes the ALU's result stream.
- On a start pulse it issues a programmed burst of cfg_count operations. Each operation uses the same op and in2; in1 advances by cfg_step per request.
- Every accepted result is folded into a rotate-XOR signature, so results can be checked without storing them.
- Used as the ALU's traffic source in subsystem tests and as a built-in self-test engine.

Parameters:
- CNT_W, 8, width of the burst count and of the response counters; maximum burst is 2^CNT_W-1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rstn  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that launches a burst; sampled only in IDLE.
- cfg_in1  input  64  in1 value for the first request.
- cfg_in2  input  64  in2 value for all requests.
- cfg_step  input  64  amount added to in1 after each accepted request.
- cfg_op  input  3  ALU op code for the burst (000 add, 001 sub, 010 xor, 110 and, 111 or).
- cfg_count  input  CNT_W  number of requests in the burst.
- rsp_hold  input  1  when 1, forces alu_out_ready low (backpressure injection).
- busy  output  1  high from the cycle after an accepted start until the DONE state.
- done  output  1  one-cycle pulse at burst completion.
- signature  output  64  rotate-XOR accumulation of the results.
- last_res  output  64  most recent accepted result.
- rsp_count  output  CNT_W  number of results accepted in the current burst.
- alu_in1  output  64  request operand 1.
- alu_in2  output  64  request operand 2.
- alu_op  output  3  request op code.
- alu_in_valid  output  1  request valid.
- alu_in_ready  input  1  request ready from the ALU.
- alu_res  input  64  ALU result.
- alu_out_valid  input  1  result valid from the ALU.
- alu_out_ready  output  1  result ready to the ALU.

Behaviour:
- Reset: rstn low asynchronously forces the state machine to IDLE and clears every register to 0. All outputs therefore read 0, including alu_in_valid, alu_out_ready, busy and done.
- Reset mid-burst abandons the burst with no done pulse. Any ALU result still pending is the ALU's concern, since the ALU is reset by the same rstn.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start=1 with cfg_count!=0 latches the cfg_* inputs and loads alu_in1/alu_in2/alu_op.
  - On that same edge it clears the issue counter, rsp_count and signature, and moves to ISSUE.
  - start=1 with cfg_count==0 moves directly to DONE, clears signature and rsp_count, and issues nothing.
- ISSUE:
  - alu_in_valid=1.
  - On each handshake (alu_in_valid & alu_in_ready): issue counter +1 and alu_in1 <= alu_in1 + cfg_step, modulo 2^64 with wrap permitted.
  - A handshake that makes the issue count equal cfg_count moves to DRAIN, and alu_in_valid drops the following cycle.
  - alu_in_valid never deasserts without a handshake. alu_in1/alu_in2/alu_op stay stable while valid is high and not yet accepted.
- DRAIN: alu_in_valid=0. When rsp_count reaches cfg_count, including via a response on the current edge, move to DONE.
- DONE: done=1 for exactly this one cycle, then IDLE. done therefore rises the cycle after the final response handshake.
- Response path, active in ISSUE and DRAIN:
  - alu_out_ready = ~rsp_hold.
  - On alu_out_valid & alu_out_ready: signature <= {signature[62:0], signature[63]} ^ alu_res; last_res <= alu_res; rsp_count +1.
  - A request handshake and a response handshake in the same cycle both take effect.
  - In IDLE and DONE, alu_out_ready=0; any stray result is not consumed.
- busy = state is ISSUE or DRAIN.
- start while busy, or in DONE, is ignored; cfg_* changes during a burst have no effect.
- signature, last_res and rsp_count hold their values after DONE until the next accepted start.

Test Plan:
- ADD burst: cfg_in1=5, in2=3, step=1, op=000, count=4, rsp_hold=0 -> results 8, 9, 10, 11; signature=123; last_res=11; rsp_count=4; exactly one done pulse, one cycle after the 4th response.
- SUB single: cfg_in1=10, in2=3, op=001, count=1 -> result 7, signature=7, rsp_count=1.
- Zero count: start with count=0 -> busy never high; done pulses the cycle after start; alu_in_valid stays 0; signature=0.
- Backpressure: repeat the ADD burst with rsp_hold=1 for cycles 2-11 of the burst -> ALU stalls and alu_in_valid stays high with stable operands. After release, same results, signature=123, rsp_count=4.
- Wrap and ignore: cfg_in1=64'hFFFF_FFFF_FFFF_FFFF, step=1, in2=0, op=000, count=2 -> results FFFF_FFFF_FFFF_FFFF then 0. A second start pulse mid-burst is ignored, giving one done pulse only.
- Async reset: rstn low in ISSUE after 2 responses -> all outputs 0 without waiting for a clock edge, state IDLE. After release, a new ADD burst produces signature=123.
